tlu_dut_handshake_rx: RTL and testbench
=======================================

Name: tlu_dut_handshake_rx

Overview:
- DUT-side responder for the TLU trigger/busy/clock handshake driven by the master's per-DUT transmitters.
- Detects an incoming trigger, raises BUSY, clocks out the serial trigger ID, and presents it as a parallel word with a valid strobe.
- Used as an on-board DUT emulator for loop-back testing of the master's outputs, and as the receive front end of a DUT readout.
- Single clock domain BUS_CLK. TLU inputs are asynchronous and synchronised internally.

Parameters:
- CLK_DIV, 4: TLU_CLOCK half-period in BUS_CLK cycles; legal range 2..255.
- TIMEOUT, 1024: BUS_CLK cycles allowed in WAIT_LOW before abort.

Ports:
- BUS_CLK  in  1  clock
- RST  in  1  synchronous, active-high reset; clock BUS_CLK
- ENABLE  in  1  accept new triggers
- N_BITS  in  5  trigger-ID length in bits, 0..31
- HOLD_BUSY  in  1  extends BUSY after ID capture (DUT readout busy)
- TLU_TRIGGER  in  1  async trigger / serial-ID line from master
- TLU_RESET  in  1  async reset line from master
- TLU_BUSY  out  1  busy to master
- TLU_CLOCK  out  1  ID shift clock to master
- TRIG_ID  out  31  last captured ID, LSB first received
- TRIG_VALID  out  1  one-cycle strobe when TRIG_ID updates
- TRIG_CNT  out  32  completed handshakes
- ERR_CNT  out  8  timeouts, saturating at 0xFF

Behaviour:
- Synchronisation: TLU_TRIGGER and TLU_RESET each pass a 2-FF synchroniser (trig_s, rst_s). trig_q holds trig_s delayed by one cycle.
- Reset: all outputs are 0, state is IDLE.
- TLU_RESET: rst_s high clears TRIG_CNT. The FSM is not affected.
- IDLE
  - If ENABLE and trig_s=1 and trig_q=0: go to WAIT_LOW and set TLU_BUSY=1 on the next cycle.
  - Edge-to-BUSY latency is 3 BUS_CLK cycles from the TLU_TRIGGER transition.
- WAIT_LOW
  - BUSY is held. A timeout counter runs.
  - If trig_s=0: go to SHIFT with bit index 0 and the shift register cleared. If N_BITS=0, go directly to DONE.
  - If the counter reaches TIMEOUT-1 first: go to RECOVER and increment ERR_CNT (saturating).
- SHIFT
  - TLU_CLOCK is high for CLK_DIV cycles, then low for CLK_DIV cycles, per bit.
  - On the last cycle of each low phase, trig_s is sampled into bit[index] and index increments.
  - After bit N_BITS-1 is sampled: go to DONE. TLU_CLOCK is 0 on exit.
- DONE (1 cycle)
  - TRIG_ID gets the shift register; bits at and above N_BITS are 0.
  - TRIG_VALID=1 and TRIG_CNT increments, wrapping.
  - Go to HOLD.
- HOLD: BUSY held while HOLD_BUSY=1, then go to IDLE with BUSY=0 on the next cycle.
- RECOVER: BUSY=0. Wait for trig_s=0 and go to IDLE. No TRIG_VALID, and TRIG_ID is unchanged.
- Re-arm guard: IDLE requires a fresh rising edge. A trigger held high through HOLD does not retrigger.
- ENABLE deasserted mid-transaction: the current handshake completes; only new triggers are blocked.
- RST mid-transaction: immediate return to IDLE with BUSY=0 and CLOCK=0. Counters are cleared.
- Simultaneous DONE and rst_s: the clear wins, so TRIG_CNT=0.
- N_BITS is sampled on entry to WAIT_LOW. Changes mid-transaction are ignored.

Decomposition:
- Package tlu_dut_pkg holds:
  - state enum IDLE, WAIT_LOW, SHIFT, DONE, HOLD, RECOVER;
  - ID_W=31, CNT_W=32, ERR_W=8.
- Sub-module tlu_dut_sync: a 2-FF synchroniser, instantiated twice (trigger, reset).
- The FSM, clock divider and shift register stay in the top.

Test Plan:
- **Basic ID capture.** CLK_DIV=4, N_BITS=15; master sends ID 0x1234 LSB first, one bit per TLU_CLOCK rising edge.
  - BUSY rises 3 cycles after TRIGGER.
  - Exactly 15 clock pulses of 8 cycles each.
  - TRIG_ID=0x1234, one TRIG_VALID pulse, TRIG_CNT=1.
- **Full-width ID.** N_BITS=31 with ID 0x7FFFFFFF, then ID 0x00000001 → two captures matching the sent IDs, TRIG_CNT=2.
- **Trigger-only mode.** N_BITS=0 → no TLU_CLOCK edges, TRIG_ID=0, TRIG_VALID once.
- **Timeout.** TIMEOUT=1024; TRIGGER held high 2000 cycles.
  - ERR_CNT=1, BUSY drops after 1024 cycles in WAIT_LOW, no TRIG_VALID.
  - No retrigger until TRIGGER goes low and then rises again.
- **HOLD_BUSY and retrigger guard.** HOLD_BUSY=1 for 50 cycles after capture → BUSY stays high 50 more cycles; a second TRIGGER edge during HOLD is ignored.
- **Mid-transaction resets.** RST asserted mid-SHIFT at bit 7 → BUSY=0 and CLOCK=0 next cycle, counters 0. TLU_RESET pulse after 3 triggers → TRIG_CNT=0, TRIG_ID retained.

Source files
------------

// File: rtl/tlu_dut_handshake_rx_pkg.sv
// tlu_dut_pkg: shared widths and FSM states for the TLU DUT-side handshake receiver
package tlu_dut_pkg;
  localparam int ID_W = 31;
  localparam int CNT_W = 32;
  localparam int ERR_W = 8;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LOW = 3'd1,
    SHIFT    = 3'd2,
    DONE     = 3'd3,
    HOLD     = 3'd4,
    RECOVER  = 3'd5
  } state_e;
endpackage

// File: rtl/tlu_dut_handshake_rx_if.sv
// tlu_dut_handshake_rx_if: TLU handshake lines plus the parallel trigger-ID side
interface tlu_dut_handshake_rx_if;
  import tlu_dut_pkg::*;
  logic ENABLE;
  logic [4:0] N_BITS;
  logic HOLD_BUSY;
  logic TLU_TRIGGER;
  logic TLU_RESET;
  logic TLU_BUSY;
  logic TLU_CLOCK;
  logic [ID_W-1:0] TRIG_ID;
  logic TRIG_VALID;
  logic [CNT_W-1:0] TRIG_CNT;
  logic [ERR_W-1:0] ERR_CNT;
  modport master (
    output ENABLE, N_BITS, HOLD_BUSY, TLU_TRIGGER, TLU_RESET,
    input  TLU_BUSY, TLU_CLOCK, TRIG_ID, TRIG_VALID, TRIG_CNT, ERR_CNT
  );
  modport slave (
    input  ENABLE, N_BITS, HOLD_BUSY, TLU_TRIGGER, TLU_RESET,
    output TLU_BUSY, TLU_CLOCK, TRIG_ID, TRIG_VALID, TRIG_CNT, ERR_CNT
  );
endinterface

// File: rtl/tlu_dut_handshake_rx_sync.sv
// tlu_dut_sync: two-flop synchroniser for an asynchronous TLU input
module tlu_dut_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q;
  always_ff @(posedge clk) ff_q <= rst ? 2'b00 : {ff_q[0], d};
  assign q = ff_q[1];
endmodule

// File: rtl/tlu_dut_handshake_rx.sv
// tlu_dut_handshake_rx: DUT-side TLU responder; raises BUSY, clocks in the serial trigger ID
module tlu_dut_handshake_rx
  import tlu_dut_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 1024
) (
  input logic BUS_CLK,
  input logic RST,
  tlu_dut_handshake_rx_if.slave bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic trig_s, trig_q, rst_s;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] div_q, div_d;
  logic clk_q, clk_d, valid_q, valid_d;
  logic [4:0] idx_q, idx_d, nb_q, nb_d;
  logic [ID_W-1:0] sr_q, sr_d, id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic div_end;
  tlu_dut_sync u_sync_trig (.clk(BUS_CLK), .rst(RST), .d(bus.TLU_TRIGGER), .q(trig_s));
  tlu_dut_sync u_sync_rst  (.clk(BUS_CLK), .rst(RST), .d(bus.TLU_RESET),   .q(rst_s));
  assign div_end = div_q == DW'(CLK_DIV - 1);
  always_comb begin
    state_d = state_q;
    tmo_d = tmo_q;
    div_d = div_q;
    clk_d = clk_q;
    idx_d = idx_q;
    nb_d = nb_q;
    sr_d = sr_q;
    id_d = id_q;
    valid_d = 1'b0;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.ENABLE && trig_s && !trig_q) begin
        state_d = WAIT_LOW;
        tmo_d = '0;
        nb_d = bus.N_BITS;
      end
      WAIT_LOW: if (!trig_s) begin
        state_d = nb_q == '0 ? DONE : SHIFT;
        idx_d = '0;
        sr_d = '0;
        div_d = '0;
        clk_d = nb_q != '0;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = RECOVER;
        err_d = &err_q ? err_q : err_q + ERR_W'(1);
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      SHIFT: begin
        div_d = div_end ? '0 : div_q + DW'(1);
        // a bit is sampled on the final cycle of each low phase
        if (div_end) begin
          clk_d = !clk_q && idx_q != nb_q - 5'd1;
          if (!clk_q) begin
            sr_d[idx_q] = trig_s;
            idx_d = idx_q + 5'd1;
            state_d = idx_q == nb_q - 5'd1 ? DONE : SHIFT;
          end
        end
      end
      DONE: begin
        id_d = sr_q;
        valid_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        state_d = HOLD;
      end
      HOLD: state_d = bus.HOLD_BUSY ? HOLD : IDLE;
      RECOVER: state_d = trig_s ? RECOVER : IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_s) cnt_d = '0;
  end
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      trig_q <= 1'b0;
      tmo_q <= '0;
      div_q <= '0;
      clk_q <= 1'b0;
      idx_q <= '0;
      nb_q <= '0;
      sr_q <= '0;
      id_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      trig_q <= trig_s;
      tmo_q <= tmo_d;
      div_q <= div_d;
      clk_q <= clk_d;
      idx_q <= idx_d;
      nb_q <= nb_d;
      sr_q <= sr_d;
      id_q <= id_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.TLU_BUSY = state_q inside {WAIT_LOW, SHIFT, DONE, HOLD};
  assign bus.TLU_CLOCK = clk_q;
  assign bus.TRIG_ID = id_q;
  assign bus.TRIG_VALID = valid_q;
  assign bus.TRIG_CNT = cnt_q;
  assign bus.ERR_CNT = err_q;
endmodule

// File: tb/tb_tlu_dut_handshake_rx.sv
// tb_tlu_dut_handshake_rx: acts as the TLU master and checks captures against a transaction-level model
module tb_tlu_dut_handshake_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int exp_err = 0;
  logic [30:0] exp_id = '0;
  int rises = 0, hi_cyc = 0, vcnt = 0, last_per = 0, cyc_n = 0, last_rise = 0;
  logic prev_clk = 1'b0;
  tlu_dut_handshake_rx_if bus ();
  tlu_dut_handshake_rx #(.CLK_DIV(4), .TIMEOUT(1024)) dut (.BUS_CLK(clk), .RST(rst), .bus(bus));
  initial forever #5 clk = ~clk;
  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (bus.TLU_CLOCK && !prev_clk) begin
      rises <= rises + 1;
      last_per <= cyc_n - last_rise;
      last_rise <= cyc_n;
    end
    if (bus.TLU_CLOCK) hi_cyc <= hi_cyc + 1;
    if (bus.TRIG_VALID) vcnt <= vcnt + 1;
    prev_clk <= bus.TLU_CLOCK;
  end
  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // one full master transaction; abort_at>=0 stops right after that bit's clock rise
  task automatic send(input logic [30:0] id, input int n, input int abort_at);
    int t, r0, h0, v0;
    logic [31:0] m;
    bus.N_BITS = 5'(n);
    bus.TLU_TRIGGER = 1'b0;
    cyc(4);
    r0 = rises; h0 = hi_cyc; v0 = vcnt;
    bus.TLU_TRIGGER = 1'b1;
    t = 0;
    while (!bus.TLU_BUSY && t < 20) begin cyc(1); t++; end
    chk("busy_latency", t, 3);
    bus.TLU_TRIGGER = 1'b0;
    bus.N_BITS = 5'($urandom);
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!bus.TLU_CLOCK && t < 100) begin cyc(1); t++; end
      if (t >= 100) chk("clock_rise_timeout", bus.TLU_CLOCK, 1);
      if (k == abort_at) return;
      bus.TLU_TRIGGER = id[k];
      t = 0;
      while (bus.TLU_CLOCK && t < 100) begin cyc(1); t++; end
      if (t >= 100) chk("clock_fall_timeout", bus.TLU_CLOCK, 0);
    end
    t = 0;
    while (!bus.TRIG_VALID && t < 300) begin cyc(1); t++; end
    m = (32'd1 << n) - 32'd1;
    exp_id = id & m[30:0];
    exp_cnt++;
    chk("valid_seen", bus.TRIG_VALID, 1);
    chk("trig_id", bus.TRIG_ID, exp_id);
    chk("trig_cnt", bus.TRIG_CNT, 32'(exp_cnt));
    cyc(1);
    chk("valid_one_cycle", bus.TRIG_VALID, 0);
    chk("valid_pulses", vcnt - v0, 1);
    chk("clock_pulses", rises - r0, n);
    chk("clock_high_cycles", hi_cyc - h0, 4 * n);
    if (n >= 2) chk("clock_period", last_per, 8);
  endtask
  initial begin
    int t, v1;
    bus.ENABLE = 1'b1;
    bus.N_BITS = '0;
    bus.HOLD_BUSY = 1'b0;
    bus.TLU_TRIGGER = 1'b0;
    bus.TLU_RESET = 1'b0;
    cyc(3);
    chk("rst_busy", bus.TLU_BUSY, 0);
    chk("rst_clock", bus.TLU_CLOCK, 0);
    chk("rst_id", bus.TRIG_ID, 0);
    chk("rst_valid", bus.TRIG_VALID, 0);
    chk("rst_cnt", bus.TRIG_CNT, 0);
    chk("rst_err", bus.ERR_CNT, 0);
    rst = 1'b0;
    cyc(2);
    send(31'h1234, 15, -1);
    send(31'h7FFFFFFF, 31, -1);
    send(31'h00000001, 31, -1);
    send(31'h5A5A5A5A, 0, -1);
    for (int i = 0; i < 6; i++) send(31'($urandom), $urandom_range(31, 1), -1);
    // timeout: trigger held high far beyond the WAIT_LOW budget
    v1 = vcnt;
    bus.TLU_TRIGGER = 1'b0;
    cyc(4);
    bus.TLU_TRIGGER = 1'b1;
    t = 0;
    while (!bus.TLU_BUSY && t < 20) begin cyc(1); t++; end
    chk("to_busy_latency", t, 3);
    t = 0;
    while (bus.TLU_BUSY && t < 3000) begin cyc(1); t++; end
    exp_err++;
    chk("to_busy_cycles", t, 1024);
    chk("to_err_cnt", bus.ERR_CNT, 8'(exp_err));
    cyc(960);
    chk("to_no_retrigger", bus.TLU_BUSY, 0);
    chk("to_no_valid", vcnt - v1, 0);
    chk("to_id_kept", bus.TRIG_ID, exp_id);
    bus.TLU_TRIGGER = 1'b0;
    cyc(5);
    chk("to_idle_low", bus.TLU_BUSY, 0);
    send(31'h2AB, 10, -1);
    // held-busy readout with an ignored second edge
    bus.HOLD_BUSY = 1'b1;
    send(31'h55, 8, -1);
    v1 = vcnt;
    bus.TLU_TRIGGER = 1'b0;
    cyc(4);
    bus.TLU_TRIGGER = 1'b1;
    cyc(44);
    chk("hold_busy_high", bus.TLU_BUSY, 1);
    bus.HOLD_BUSY = 1'b0;
    cyc(1);
    chk("hold_release", bus.TLU_BUSY, 0);
    cyc(10);
    chk("hold_retrigger_guard", bus.TLU_BUSY, 0);
    chk("hold_cnt", bus.TRIG_CNT, 32'(exp_cnt));
    chk("hold_no_valid", vcnt - v1, 0);
    // disabled: new edges are not accepted
    bus.ENABLE = 1'b0;
    bus.TLU_TRIGGER = 1'b0;
    cyc(4);
    bus.TLU_TRIGGER = 1'b1;
    cyc(10);
    chk("disabled_busy", bus.TLU_BUSY, 0);
    bus.ENABLE = 1'b1;
    // bus reset in the middle of shifting bit 7
    send(31'h7FFF, 15, 7);
    chk("mid_shift_busy", bus.TLU_BUSY, 1);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_busy", bus.TLU_BUSY, 0);
    chk("rst_mid_clock", bus.TLU_CLOCK, 0);
    chk("rst_mid_cnt", bus.TRIG_CNT, 0);
    chk("rst_mid_err", bus.ERR_CNT, 0);
    rst = 1'b0;
    exp_cnt = 0;
    exp_err = 0;
    exp_id = '0;
    for (int i = 0; i < 3; i++) send(31'($urandom), $urandom_range(12, 1), -1);
    chk("pre_tlu_reset_cnt", bus.TRIG_CNT, 3);
    bus.TLU_RESET = 1'b1;
    cyc(3);
    bus.TLU_RESET = 1'b0;
    cyc(4);
    exp_cnt = 0;
    chk("tlu_reset_cnt", bus.TRIG_CNT, 0);
    chk("tlu_reset_id_kept", bus.TRIG_ID, exp_id);
    send(31'h3C, 6, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
